br_delay_valid_rx_fifo: RTL and testbench

//   Credit-returning receive buffer that sits directly downstream of a fixed-latency

---
 rtl/br_delay_valid_rx_fifo_pkg.sv | 13 +
 rtl/br_delay_valid_rx_fifo_ctrl.sv | 79 +++++++
 rtl/br_delay_valid_rx_fifo.sv | 75 +++++++
 tb/tb_br_delay_valid_rx_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/br_delay_valid_rx_fifo_pkg.sv
// Shared sizing helpers for the credit-returning receive FIFO.
package br_delay_valid_rx_fifo_pkg;

    // Pointer width; a one-entry FIFO still carries a one-bit (constant 0) pointer.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/br_delay_valid_rx_fifo_ctrl.sv
// Control path of the receive FIFO: pointers, occupancy, status flags and credit pulse.
module br_delay_valid_rx_fifo_ctrl
    import br_delay_valid_rx_fifo_pkg::*;
#(
    parameter int unsigned Depth      = 2,
    parameter int unsigned AddrWidth  = addr_width(Depth),
    parameter int unsigned CountWidth = count_width(Depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    output logic                  wr_en,
    output logic [AddrWidth-1:0]  wr_ptr,
    output logic [AddrWidth-1:0]  rd_ptr,
    output logic [CountWidth-1:0] items,
    output logic                  out_valid,
    output logic                  full,
    output logic                  overflow,
    output logic                  credit_return
);

    localparam logic [AddrWidth-1:0] LastPtr = AddrWidth'(Depth - 1);

    logic [AddrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0] items_q, items_d;
    logic                  out_valid_q, out_valid_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  credit_return_q, credit_return_d;
    logic                  push_acc;

    // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        push_acc        = push && (!full_q || pop);
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        if (push_acc) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        if (pop)      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        items_d         = items_q + CountWidth'(push_acc) - CountWidth'(pop);
        out_valid_d     = (items_d != '0);
        full_d          = (items_d == CountWidth'(Depth));
        // A push that could not be accepted is dropped and latched as an error until reset.
        overflow_d      = overflow_q | (push && !push_acc);
        credit_return_d = pop;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            items_q         <= '0;
            out_valid_q     <= 1'b0;
            full_q          <= 1'b0;
            overflow_q      <= 1'b0;
            credit_return_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            items_q         <= items_d;
            out_valid_q     <= out_valid_d;
            full_q          <= full_d;
            overflow_q      <= overflow_d;
            credit_return_q <= credit_return_d;
        end
    end

    assign wr_en         = push_acc;
    assign wr_ptr        = wr_ptr_q;
    assign rd_ptr        = rd_ptr_q;
    assign items         = items_q;
    assign out_valid     = out_valid_q;
    assign full          = full_q;
    assign overflow      = overflow_q;
    assign credit_return = credit_return_q;

endmodule

// File: rtl/br_delay_valid_rx_fifo.sv
// Receive FIFO behind a valid-only delay line: absorbs pushes without backpressure,
// presents ready/valid downstream and returns one credit per popped entry.
module br_delay_valid_rx_fifo
    import br_delay_valid_rx_fifo_pkg::*;
#(
    parameter int unsigned Width             = 1,
    parameter int unsigned Depth             = 2,
    parameter bit          EnableIntegAssert = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [Width-1:0]              in,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [Width-1:0]              out,
    output logic                          credit_return,
    output logic [count_width(Depth)-1:0] items,
    output logic                          full,
    output logic                          overflow
);

    localparam int unsigned AddrWidth  = addr_width(Depth);
    localparam int unsigned CountWidth = count_width(Depth);

    logic                 push, pop, wr_en;
    logic [AddrWidth-1:0] wr_ptr, rd_ptr;
    logic [Width-1:0]     mem_q [Depth];

    assign push = in_valid;
    assign pop  = out_valid && out_ready;

    br_delay_valid_rx_fifo_ctrl #(
        .Depth      (Depth),
        .AddrWidth  (AddrWidth),
        .CountWidth (CountWidth)
    ) u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .pop           (pop),
        .wr_en         (wr_en),
        .wr_ptr        (wr_ptr),
        .rd_ptr        (rd_ptr),
        .items         (items),
        .out_valid     (out_valid),
        .full          (full),
        .overflow      (overflow),
        .credit_return (credit_return)
    );

    // NOTE: storage has no reset; occupancy gates its visibility, and a reset-free array maps to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= in;
    end

    assign out = mem_q[rd_ptr];

`ifndef SYNTHESIS
    if (EnableIntegAssert) begin : g_integ_assert
        a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
            !(push && full && !out_ready));
    end

    a_items_bound  : assert property (@(posedge clk) disable iff (rst)
        items <= CountWidth'(Depth));
    a_valid_match  : assert property (@(posedge clk) disable iff (rst)
        out_valid == (items != '0));
    a_full_match   : assert property (@(posedge clk) disable iff (rst)
        full == (items == CountWidth'(Depth)));
    a_out_stable   : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && out == $past(out)));
`endif

endmodule

// File: tb/tb_br_delay_valid_rx_fifo.sv
// Directed bench: Depth=4 instance for fill/drain/overflow/reset, Depth=3 instance for wrap.
module tb_br_delay_valid_rx_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Depth=4 instance; overflow is provoked on purpose, so its integration check is off.
    logic       a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [7:0] a_in = '0, a_out;
    logic       a_out_valid, a_credit, a_full, a_overflow;
    logic [2:0] a_items;

    br_delay_valid_rx_fifo #(.Width(8), .Depth(4), .EnableIntegAssert(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in(a_in), .out_ready(a_out_ready),
        .out_valid(a_out_valid), .out(a_out), .credit_return(a_credit),
        .items(a_items), .full(a_full), .overflow(a_overflow)
    );

    logic       b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [7:0] b_in = '0, b_out;
    logic       b_out_valid, b_credit, b_full, b_overflow;
    logic [1:0] b_items;

    br_delay_valid_rx_fifo #(.Width(8), .Depth(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in(b_in), .out_ready(b_out_ready),
        .out_valid(b_out_valid), .out(b_out), .credit_return(b_credit),
        .items(b_items), .full(b_full), .overflow(b_overflow)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_fill(input logic [7:0] v0, input logic [7:0] v1,
                          input logic [7:0] v2, input logic [7:0] v3);
        logic [7:0] vals [4];
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in       = vals[i];
            tick();
        end
        a_in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        int         b_exp, b_credits;

        tick();
        tick();
        rst = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            check("idle_valid",  32'(a_out_valid), 0);
            check("idle_items",  32'(a_items), 0);
            check("idle_credit", 32'(a_credit), 0);
            check("idle_ovf",    32'(a_overflow), 0);
            tick();
        end

        // Back-to-back fill, then drain with one-cycle credit lag
        a_fill(8'h11, 8'h22, 8'h33, 8'h44);
        check("fill_items", 32'(a_items), 4);
        check("fill_full",  32'(a_full), 1);
        check("fill_valid", 32'(a_out_valid), 1);
        check("fill_head",  32'(a_out), 32'h11);
        tick();
        check("fill_hold_head", 32'(a_out), 32'h11);
        check("pre_pop_credit", 32'(a_credit), 0);
        a_out_ready = 1'b1;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            check("drain_out",   32'(a_out), 32'(exp_q[i]));
            check("drain_valid", 32'(a_out_valid), 1);
            tick();
            check("drain_credit", 32'(a_credit), 1);
            check("drain_items",  32'(a_items), 32'(3 - i));
        end
        check("drain_empty", 32'(a_out_valid), 0);
        check("drain_full",  32'(a_full), 0);
        tick();
        check("credit_stop", 32'(a_credit), 0);
        check("empty_ready_items", 32'(a_items), 0);
        a_out_ready = 1'b0;

        // Full with simultaneous push and pop
        a_fill(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        a_in_valid  = 1'b1;
        a_in        = 8'h55;
        a_out_ready = 1'b1;
        check("pp_head", 32'(a_out), 32'hA1);
        tick();
        a_in_valid = 1'b0;
        check("pp_items", 32'(a_items), 4);
        check("pp_ovf",   32'(a_overflow), 0);
        check("pp_full",  32'(a_full), 1);
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'h55};
        for (int i = 0; i < 4; i++) begin
            check("pp_out", 32'(a_out), 32'(exp_q[i]));
            tick();
        end
        check("pp_empty", 32'(a_out_valid), 0);
        a_out_ready = 1'b0;

        // Full with push and no pop: drop and sticky overflow
        a_fill(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        a_in_valid = 1'b1;
        a_in       = 8'h66;
        tick();
        a_in_valid = 1'b0;
        check("ovf_set",   32'(a_overflow), 1);
        check("ovf_items", 32'(a_items), 4);
        check("ovf_head",  32'(a_out), 32'hB1);
        a_out_ready = 1'b1;
        exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        for (int i = 0; i < 4; i++) begin
            check("ovf_out", 32'(a_out), 32'(exp_q[i]));
            tick();
        end
        check("ovf_no_66", 32'(a_out_valid), 0);
        tick();
        tick();
        check("ovf_sticky", 32'(a_overflow), 1);
        check("ovf_items0", 32'(a_items), 0);
        a_out_ready = 1'b0;

        // Asynchronous reset mid-stream with two entries and a credit in flight
        a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in = 8'hC1 + 8'(i);
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check("pre_rst_items",  32'(a_items), 2);
        check("pre_rst_credit", 32'(a_credit), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",  32'(a_out_valid), 0);
        check("arst_items",  32'(a_items), 0);
        check("arst_credit", 32'(a_credit), 0);
        check("arst_ovf",    32'(a_overflow), 0);
        tick();
        rst = 1'b0;
        a_out_ready = 1'b1;
        tick();
        tick();
        check("post_rst_valid",  32'(a_out_valid), 0);
        check("post_rst_credit", 32'(a_credit), 0);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in        = 8'hD1;
        tick();
        a_in_valid = 1'b0;
        check("post_rst_push_valid", 32'(a_out_valid), 1);
        check("post_rst_push_out",   32'(a_out), 32'hD1);
        check("post_rst_push_items", 32'(a_items), 1);

        // Depth=3 wrap: 10 pushes at one per cycle with the consumer always ready
        b_exp       = 0;
        b_credits   = 0;
        b_out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            b_in_valid = (c < 10);
            b_in       = 8'(c);
            tick();
            if (b_out_valid) begin
                check("wrap_out", 32'(b_out), 32'(b_exp));
                b_exp++;
            end
            if (b_credit) b_credits++;
            check("wrap_items_le1", 32'(b_items <= 2'd1), 1);
        end
        check("wrap_count",   32'(b_exp), 10);
        check("wrap_credits", 32'(b_credits), 10);
        check("wrap_ovf",     32'(b_overflow), 0);
        check("wrap_full",    32'(b_full), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
